// File: rtl/ppu_palette_rgb_if.sv
`default_nettype none
// ============================================================================
// ppu_palette_rgb_if : pixel-in, palette-write and RGB-out bundle
// Rev 1.0
// ============================================================================
interface ppu_palette_rgb_if #(
  parameter int COLOR_BITS = 8
);
  logic                    i_valid;
  logic [5:0]              i_color;
  logic                    i_grey;
  logic [2:0]              i_emph;
  logic                    i_wr_en;
  logic [5:0]              i_wr_addr;
  logic [23:0]             i_wr_data;
  logic                    o_ready;
  logic                    o_valid;
  logic [3*COLOR_BITS-1:0] o_rgb;

  modport master (
    output i_valid, i_color, i_grey, i_emph, i_wr_en, i_wr_addr, i_wr_data,
    input  o_ready, o_valid, o_rgb
  );

  modport slave (
    input  i_valid, i_color, i_grey, i_emph, i_wr_en, i_wr_addr, i_wr_data,
    output o_ready, o_valid, o_rgb
  );
endinterface
`default_nettype wire

// File: rtl/ppu_palette_rgb.sv
`default_nettype none
// ============================================================================
// ppu_palette_rgb : RAM-based NES colour index to RGB, greyscale/emphasis aware
// Rev 1.0
// ============================================================================
module ppu_palette_rgb #(
  parameter int COLOR_BITS = 8,
  parameter int EMPH_ATTEN = 192
) (
  input  logic             i_clk,
  input  logic             i_rst,
  ppu_palette_rgb_if.slave bus
);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [7:0] C_ATTEN = 8'(EMPH_ATTEN);

  state_t      r_state;
  logic [5:0]  r_init_cnt;
  logic        r_ready;
  logic [23:0] r_pal [64];

  logic        w_we;
  logic [5:0]  w_waddr;
  logic [23:0] w_wdata;
  logic [5:0]  w_eff_idx;
  logic        w_exempt;
  logic [2:0]  w_atten;

  logic        r_s1_valid;
  logic [23:0] r_s1_data;
  logic [2:0]  r_s1_atten;
  logic        r_s2_valid;
  logic [7:0]  r_s2_r;
  logic [7:0]  r_s2_g;
  logic [7:0]  r_s2_b;
  logic        r_out_valid;
  logic [3*COLOR_BITS-1:0] r_rgb;

  function automatic logic [23:0] default_entry(input logic [5:0] k);
    logic [23:0] e;
    e = 24'h000000;
    case (k)
      6'h00: e = 24'h757575; 6'h01: e = 24'h271B8F; 6'h02: e = 24'h0000AB; 6'h03: e = 24'h47009F;
      6'h04: e = 24'h8F0077; 6'h05: e = 24'hAB0013; 6'h06: e = 24'hA70000; 6'h07: e = 24'h7F0B00;
      6'h08: e = 24'h432F00; 6'h09: e = 24'h004700; 6'h0A: e = 24'h005100; 6'h0B: e = 24'h003F17;
      6'h0C: e = 24'h1B3F5F;
      6'h10: e = 24'hBCBCBC; 6'h11: e = 24'h0073EF; 6'h12: e = 24'h233BEF; 6'h13: e = 24'h8300F3;
      6'h14: e = 24'hBF00BF; 6'h15: e = 24'hE7005B; 6'h16: e = 24'hDB2B00; 6'h17: e = 24'hCB4F0F;
      6'h18: e = 24'h8B7300; 6'h19: e = 24'h009700; 6'h1A: e = 24'h00AB00; 6'h1B: e = 24'h00933B;
      6'h1C: e = 24'h00838B;
      6'h20: e = 24'hFFFFFF; 6'h21: e = 24'h3FBFFF; 6'h22: e = 24'h5F97FF; 6'h23: e = 24'hA78BFD;
      6'h24: e = 24'hF77BFF; 6'h25: e = 24'hFF77B7; 6'h26: e = 24'hFF7763; 6'h27: e = 24'hFF9B3B;
      6'h28: e = 24'hF3BF3F; 6'h29: e = 24'h83D313; 6'h2A: e = 24'h4FDF4B; 6'h2B: e = 24'h58F898;
      6'h2C: e = 24'h00EBDB;
      6'h30: e = 24'hFFFFFF; 6'h31: e = 24'hABE7FF; 6'h32: e = 24'hC7D7FF; 6'h33: e = 24'hD7CBFF;
      6'h34: e = 24'hFFC7FF; 6'h35: e = 24'hFFC7DB; 6'h36: e = 24'hFFBFB3; 6'h37: e = 24'hFFDBAB;
      6'h38: e = 24'hFFE7A3; 6'h39: e = 24'hE3FFA3; 6'h3A: e = 24'hABF3BF; 6'h3B: e = 24'hB3FFCF;
      6'h3C: e = 24'h9FFFF3;
      default: e = 24'h000000;
    endcase
    return e;
  endfunction

  function automatic logic [7:0] scale(input logic [7:0] ch);
    logic [15:0] p;
    p = {8'd0, ch} * {8'd0, C_ATTEN};
    return p[15:8];
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_INIT;
      r_init_cnt <= 6'd0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_init_cnt <= r_init_cnt + 6'd1;
          if (r_init_cnt == 6'd63) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
          end
        end
        default: r_ready <= 1'b1;
      endcase
    end
  end

  // The init walker owns the write port until RUN; host writes are dropped before then.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_init_cnt;
    w_wdata = default_entry(r_init_cnt);
    if (!i_rst) begin
      if (r_state == S_INIT) begin
        w_we = 1'b1;
      end else if (bus.i_wr_en) begin
        w_we    = 1'b1;
        w_waddr = bus.i_wr_addr;
        w_wdata = bus.i_wr_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_pal[w_waddr] <= w_wdata;
    end
  end

  always_comb begin
    w_eff_idx = bus.i_grey ? (bus.i_color & 6'h30) : bus.i_color;
    w_exempt  = (w_eff_idx[3:1] == 3'b111);
    w_atten   = 3'b000;
    for (int c = 0; c < 3; c++) begin
      w_atten[c] = !w_exempt && (bus.i_emph != 3'b000) &&
                   ((bus.i_emph == 3'b111) || !bus.i_emph[c]);
    end
  end

  // Read is sampled alongside the index, so a same-edge host write is seen one pixel later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= bus.i_valid && (r_state == S_RUN);
      r_s2_valid <= r_s1_valid;
    end
    r_s1_data  <= r_pal[w_eff_idx];
    r_s1_atten <= w_atten;
    r_s2_r     <= r_s1_atten[0] ? scale(r_s1_data[23:16]) : r_s1_data[23:16];
    r_s2_g     <= r_s1_atten[1] ? scale(r_s1_data[15:8])  : r_s1_data[15:8];
    r_s2_b     <= r_s1_atten[2] ? scale(r_s1_data[7:0])   : r_s1_data[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_rgb       <= '0;
    end else begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_rgb <= {r_s2_r[7 -: COLOR_BITS], r_s2_g[7 -: COLOR_BITS], r_s2_b[7 -: COLOR_BITS]};
      end
    end
  end

  assign bus.o_ready = r_ready;
  assign bus.o_valid = r_out_valid;
  assign bus.o_rgb   = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_ppu_palette_rgb.sv
`default_nettype none
// ============================================================================
// tb_ppu_palette_rgb : model-checked bench, 8-bit and 5-bit channel instances
// Rev 1.0
// ============================================================================
module tb_ppu_palette_rgb;

  localparam int ATTEN = 192;

  localparam logic [23:0] DEF [64] = '{
    24'h757575, 24'h271B8F, 24'h0000AB, 24'h47009F, 24'h8F0077, 24'hAB0013, 24'hA70000, 24'h7F0B00,
    24'h432F00, 24'h004700, 24'h005100, 24'h003F17, 24'h1B3F5F, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0073EF, 24'h233BEF, 24'h8300F3, 24'hBF00BF, 24'hE7005B, 24'hDB2B00, 24'hCB4F0F,
    24'h8B7300, 24'h009700, 24'h00AB00, 24'h00933B, 24'h00838B, 24'h000000, 24'h000000, 24'h000000,
    24'hFFFFFF, 24'h3FBFFF, 24'h5F97FF, 24'hA78BFD, 24'hF77BFF, 24'hFF77B7, 24'hFF7763, 24'hFF9B3B,
    24'hF3BF3F, 24'h83D313, 24'h4FDF4B, 24'h58F898, 24'h00EBDB, 24'h000000, 24'h000000, 24'h000000,
    24'hFFFFFF, 24'hABE7FF, 24'hC7D7FF, 24'hD7CBFF, 24'hFFC7FF, 24'hFFC7DB, 24'hFFBFB3, 24'hFFDBAB,
    24'hFFE7A3, 24'hE3FFA3, 24'hABF3BF, 24'hB3FFCF, 24'h9FFFF3, 24'h000000, 24'h000000, 24'h000000
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v = 1'b0;
  logic [5:0] color = '0;
  logic grey = 1'b0;
  logic [2:0] emph = '0;
  logic wr_en = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [23:0] wr_data = '0;

  always #5 clk = ~clk;

  ppu_palette_rgb_if #(.COLOR_BITS(8)) if8 ();
  ppu_palette_rgb_if #(.COLOR_BITS(5)) if5 ();

  assign if8.i_valid = v;      assign if5.i_valid = v;
  assign if8.i_color = color;  assign if5.i_color = color;
  assign if8.i_grey = grey;    assign if5.i_grey = grey;
  assign if8.i_emph = emph;    assign if5.i_emph = emph;
  assign if8.i_wr_en = wr_en;  assign if5.i_wr_en = wr_en;
  assign if8.i_wr_addr = wr_addr; assign if5.i_wr_addr = wr_addr;
  assign if8.i_wr_data = wr_data; assign if5.i_wr_data = wr_data;

  ppu_palette_rgb #(.COLOR_BITS(8), .EMPH_ATTEN(ATTEN)) u_dut8 (.i_clk(clk), .i_rst(rst), .bus(if8.slave));
  ppu_palette_rgb #(.COLOR_BITS(5), .EMPH_ATTEN(ATTEN)) u_dut5 (.i_clk(clk), .i_rst(rst), .bus(if5.slave));

  int n_tests = 0;
  int n_fail = 0;

  // Reference model state
  typedef struct packed { logic v; logic [23:0] rgb; } pix_t;
  pix_t        pipe[$];
  logic [23:0] pal [64];
  bit          m_run = 1'b0;
  int          m_init = 0;
  logic        m_ov = 1'b0;
  logic [23:0] m_last = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] ref_rgb(input logic [5:0] c, input logic g, input logic [2:0] e);
    int idx, ch, res;
    idx = g ? (int'(c) / 16) * 16 : int'(c);
    res = 0;
    for (int i = 0; i < 3; i++) begin
      ch = int'((pal[idx] >> (16 - 8 * i)) & 24'hFF);
      if (e != 0 && (idx % 16) < 14 && (e == 7 || ((int'(e) >> i) % 2) == 0))
        ch = ch * ATTEN / 256;
      res = res * 256 + ch;
    end
    return 24'(res);
  endfunction

  function automatic logic [14:0] to5(input logic [23:0] c);
    int r, g, b;
    r = int'(c / 65536) / 8;
    g = int'((c / 256) % 256) / 8;
    b = int'(c % 256) / 8;
    return 15'(r * 1024 + g * 32 + b);
  endfunction

  // One clock edge: advance the model with the current inputs, then compare all outputs.
  task automatic step();
    pix_t p;
    p.v   = m_run && v;
    p.rgb = ref_rgb(color, grey, emph);
    if (rst) begin
      m_run = 1'b0; m_init = 0; m_ov = 1'b0; m_last = '0;
      pipe.delete();
      for (int k = 0; k < 64; k++) pal[k] = DEF[k];
    end else begin
      pipe.push_back(p);
      m_ov = 1'b0;
      if (pipe.size() > 2) begin
        p = pipe.pop_front();
        m_ov = p.v;
        if (p.v) m_last = p.rgb;
      end
      if (m_run && wr_en) pal[wr_addr] = wr_data;
      if (!m_run) begin
        m_init++;
        if (m_init == 64) m_run = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("ready8", 32'(if8.o_ready), 32'(m_run));
    check("ready5", 32'(if5.o_ready), 32'(m_run));
    check("valid8", 32'(if8.o_valid), 32'(m_ov));
    check("valid5", 32'(if5.o_valid), 32'(m_ov));
    check("rgb8", 32'(if8.o_rgb), 32'(m_last));
    check("rgb5", 32'(if5.o_rgb), 32'(to5(m_last)));
  endtask

  task automatic pix(input logic [5:0] c, input logic g, input logic [2:0] e);
    v = 1'b1; color = c; grey = g; emph = e;
    step();
    v = 1'b0;
  endtask

  task automatic idle();
    v = 1'b0;
    step();
  endtask

  task automatic run_init(input bit junk);
    for (int k = 0; k < 64; k++) begin
      v = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      color = 6'($urandom);
      wr_en = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      wr_addr = 6'($urandom);
      wr_data = 24'($urandom);
      step();
      check("ready_during_init", 32'(if8.o_ready), (k == 63) ? 32'd1 : 32'd0);
    end
    v = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    logic [14:0] exp5;
    rst = 1'b1;
    step();
    step();
    check("reset_rgb", 32'(if8.o_rgb), 32'd0);
    check("reset_valid", 32'(if8.o_valid), 32'd0);
    rst = 1'b0;
    run_init(1'b1);

    pix(6'h01, 1'b0, 3'd0); idle(); idle();
    check("first_271B8F", 32'(if8.o_rgb), 32'h271B8F);

    pix(6'h00, 1'b0, 3'd0); pix(6'h20, 1'b0, 3'd0); pix(6'h16, 1'b0, 3'd0);
    check("stream_00", 32'(if8.o_rgb), 32'h757575);
    pix(6'h0E, 1'b0, 3'd0);
    check("stream_20", 32'(if8.o_rgb), 32'hFFFFFF);
    idle();
    check("stream_16", 32'(if8.o_rgb), 32'hDB2B00);
    idle();
    check("stream_0E", 32'(if8.o_rgb), 32'h000000);

    pix(6'h16, 1'b1, 3'd0); idle(); idle();
    check("grey_16", 32'(if8.o_rgb), 32'hBCBCBC);
    pix(6'h20, 1'b0, 3'b001); idle(); idle();
    check("emph_001", 32'(if8.o_rgb), 32'hFFBFBF);
    pix(6'h20, 1'b0, 3'b111); idle(); idle();
    check("emph_111", 32'(if8.o_rgb), 32'hBFBFBF);
    pix(6'h0F, 1'b0, 3'b110); idle(); idle();
    check("emph_exempt_0F", 32'(if8.o_rgb), 32'h000000);
    pix(6'h21, 1'b0, 3'd0); idle(); idle();
    exp5 = {5'h07, 5'h17, 5'h1F};
    check("bits5_21", 32'(if5.o_rgb), 32'(exp5));

    // Host write colliding with a read of the same entry
    wr_en = 1'b1; wr_addr = 6'h00; wr_data = 24'h123456;
    pix(6'h00, 1'b0, 3'd0);
    wr_en = 1'b0;
    pix(6'h00, 1'b0, 3'd0);
    idle();
    check("collide_old", 32'(if8.o_rgb), 32'h757575);
    idle();
    check("collide_new", 32'(if8.o_rgb), 32'h123456);

    rst = 1'b1; step(); rst = 1'b0;
    run_init(1'b0);
    pix(6'h00, 1'b0, 3'd0); idle(); idle();
    check("reload_00", 32'(if8.o_rgb), 32'h757575);

    // Reset with two pixels in flight, then reset again part-way through init
    pix(6'($urandom), 1'b0, 3'd0);
    pix(6'($urandom), 1'b0, 3'd0);
    rst = 1'b1; v = 1'b1; step(); rst = 1'b0; v = 1'b0;
    check("midrst_ready", 32'(if8.o_ready), 32'd0);
    check("midrst_valid", 32'(if8.o_valid), 32'd0);
    for (int k = 0; k < 10; k++) idle();
    rst = 1'b1; step(); rst = 1'b0;
    run_init(1'b1);

    for (int k = 0; k < 400; k++) begin
      v = 1'($urandom_range(0, 3) != 0);
      color = 6'($urandom);
      grey = 1'($urandom_range(0, 3) == 0);
      emph = 3'($urandom);
      wr_en = 1'($urandom_range(0, 5) == 0);
      wr_addr = 6'($urandom);
      wr_data = 24'($urandom);
      step();
    end
    v = 1'b0; wr_en = 1'b0;
    idle(); idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
